// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// The FSM state type and the index wrap used when advancing the pointer.
package wrr_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } wrr_state_e;

  function automatic int idx_wrap(input int idx, input int ports);
    int res;
    if (idx >= ports) begin
      res = idx - ports;
    end else begin
      res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_select.sv
// Combinational round-robin selector: lowest request at or above ptr_i,
// otherwise the lowest request overall.
module rr_select #(
  parameter int PORTS = 4,
  parameter int IDX_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [PORTS-1:0] onehot_o
);

  logic [PORTS-1:0] masked_s;
  logic             hit_hi_s;
  logic             hit_lo_s;
  logic [IDX_W-1:0] idx_hi_s;
  logic [IDX_W-1:0] idx_lo_s;

  // Two passes scanned from the top so the lowest set index wins each pass.
  always_comb begin
    masked_s = '0;
    hit_hi_s = 1'b0;
    hit_lo_s = 1'b0;
    idx_hi_s = '0;
    idx_lo_s = '0;
    for (int i = 0; i < PORTS; i++) begin
      masked_s[i] = req_i[i] & (IDX_W'(i) >= ptr_i);
    end
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx_hi_s = masked_s[i] ? IDX_W'(i) : idx_hi_s;
      hit_hi_s = hit_hi_s | masked_s[i];
      idx_lo_s = req_i[i] ? IDX_W'(i) : idx_lo_s;
      hit_lo_s = hit_lo_s | req_i[i];
    end
  end

  assign valid_o  = hit_hi_s | hit_lo_s;
  assign idx_o    = hit_hi_s ? idx_hi_s : idx_lo_s;
  assign onehot_o = valid_o ? (PORTS'(1) << idx_o) : '0;

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered grant and per-port beat quotas.
// Release and re-grant happen on the same edge, so turns switch without a bubble.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W   = $clog2(PORTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORTS-1:0]          request,
  input  logic [PORTS*WEIGHT_W-1:0] weight,
  input  logic                      ack,
  input  logic                      last,
  output logic [PORTS-1:0]          grant,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_encoded,
  output logic [WEIGHT_W-1:0]       credit
);

  wrr_state_e          state_q, state_d;
  logic [PORTS-1:0]    grant_q, grant_d;
  logic                gvalid_q, gvalid_d;
  logic [IDX_W-1:0]    genc_q, genc_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;

  logic                in_grant_s;
  logic                abandon_s;
  logic                release_s;
  logic [IDX_W-1:0]    nxt_ptr_s;
  logic [IDX_W-1:0]    sel_ptr_s;
  logic [PORTS-1:0]    sel_req_s;
  logic                sel_valid_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic [PORTS-1:0]    sel_onehot_s;
  logic [WEIGHT_W-1:0] weight_sel_s;
  logic [WEIGHT_W-1:0] load_credit_s;

  // Release decode; the selector sees the advanced pointer on a release edge.
  always_comb begin
    in_grant_s = (state_q == GRANT);
    abandon_s  = in_grant_s && !request[genc_q] && !ack;
    release_s  = (in_grant_s && ack && last) ||
                 (in_grant_s && ack && (credit_q == WEIGHT_W'(1))) ||
                 abandon_s;
    nxt_ptr_s  = IDX_W'(idx_wrap(int'(genc_q) + 1, PORTS));
    sel_ptr_s  = release_s ? nxt_ptr_s : ptr_q;
    sel_req_s  = abandon_s ? (request & ~grant_q) : request;
  end

  rr_select #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req_i    (sel_req_s),
    .ptr_i    (sel_ptr_s),
    .valid_o  (sel_valid_s),
    .idx_o    (sel_idx_s),
    .onehot_o (sel_onehot_s)
  );

  // Quota of the candidate port; a zero weight still buys one beat.
  always_comb begin
    weight_sel_s = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (sel_idx_s == IDX_W'(i)) begin
        weight_sel_s = weight[i*WEIGHT_W +: WEIGHT_W];
      end else begin
        weight_sel_s = weight_sel_s;
      end
    end
    load_credit_s = (weight_sel_s == '0) ? WEIGHT_W'(1) : weight_sel_s;
  end

  // Next-state logic for the FSM, pointer, credit and output registers.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gvalid_d = gvalid_q;
    genc_d   = genc_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_valid_s) begin
          state_d  = GRANT;
          grant_d  = sel_onehot_s;
          gvalid_d = 1'b1;
          genc_d   = sel_idx_s;
          credit_d = load_credit_s;
        end else begin
          grant_d  = '0;
          gvalid_d = 1'b0;
          genc_d   = '0;
          credit_d = '0;
        end
      end
      GRANT: begin
        if (release_s) begin
          ptr_d = nxt_ptr_s;
          if (sel_valid_s) begin
            state_d  = GRANT;
            grant_d  = sel_onehot_s;
            gvalid_d = 1'b1;
            genc_d   = sel_idx_s;
            credit_d = load_credit_s;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            gvalid_d = 1'b0;
            genc_d   = '0;
            credit_d = '0;
          end
        end else if (ack) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end else begin
          credit_d = credit_q;
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        gvalid_d = 1'b0;
        genc_d   = '0;
        credit_d = '0;
        ptr_d    = '0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gvalid_q <= 1'b0;
      genc_q   <= '0;
      credit_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gvalid_q <= gvalid_d;
      genc_q   <= genc_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = gvalid_q;
  assign grant_encoded = genc_q;
  assign credit        = credit_q;

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Parametrised weighted round-robin arbiter with registered grant and per-port beat quotas. It is the next-generation shared-resource arbiter for the interconnect. Each granted port holds the resource for up to its programmed number of acknowledged beats, or until it signals end of packet. Arbitration then passes to the next requester in circular order with no idle bubble.

## Interface
- `PORTS`, default 4: number of requesters, minimum 2.
- `WEIGHT_W`, default 4: width of each per-port weight field.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `request`  in  PORTS: per-port request level.
- `weight`  in  PORTS*WEIGHT_W: per-port beat quota; port i occupies bits [i*WEIGHT_W +: WEIGHT_W].
- `ack`  in  1: one beat accepted by the currently granted port this cycle.
- `last`  in  1: the beat acknowledged this cycle ends the packet.
- `grant`  out  PORTS: one-hot registered grant.
- `grant_valid`  out  1: a grant is held.
- `grant_encoded`  out  $clog2(PORTS): index of the granted port.
- `credit`  out  WEIGHT_W: beats remaining in the current turn.

## Operation
- Two states: IDLE and GRANT.
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - State goes to IDLE.
  - `grant`=0, `grant_valid`=0, `grant_encoded`=0, `credit`=0.
  - Round-robin pointer `ptr`=0, so port 0 has highest priority first.
- Selection: pick the lowest index ≥ `ptr` with `request` set; if there is none, wrap and pick the lowest set index overall.
- IDLE:
  - If any `request` bit is set, register the selected port k: `grant`=1<<k, `grant_valid`=1, `grant_encoded`=k.
  - Load `credit` = weight[k], with weight 0 treated as 1. Go to GRANT.
- GRANT, release conditions (any one):
  - (a) `ack` && `last`.
  - (b) `ack` && `credit`==1.
  - (c) `request[k]`==0 && !`ack` (requester abandoned).
- GRANT, no release: if `ack` is high, `credit` decrements by 1. All other outputs hold.
- GRANT, on release: `ptr` becomes (k+1) mod PORTS. The same edge performs a new selection using the updated pointer and current `request`, but with `request[k]` excluded under condition (c).
  - Some port found: stay in GRANT and load that port and its weight.
  - None found: go to IDLE with all outputs cleared to reset values.
- A port that is the only requester is re-granted back-to-back with a fresh credit.
- `ack` and `last` are ignored when `grant_valid`=0.
- `weight` is sampled only at grant load; changing it mid-turn has no effect until the next grant.
- `credit` never underflows: a grant is always released when it would reach 0.

## Timing
- Request to grant: 1 cycle. `request` seen at edge n gives `grant_valid` high after edge n.
- Release to next grant: 0 idle cycles. The final `ack` at edge n is followed by the next port's grant after edge n.
- All outputs are registered; there is no combinational path from any input to any output.
- Maximum throughput: one beat per cycle per granted port.

## Structure
- Package `wrr_arbiter_pkg`:
  - State enum `wrr_state_e` {IDLE, GRANT}.
  - Helper function `idx_wrap(idx, PORTS)`.
- Sub-module `rr_select`: masked two-pass priority selector. Inputs are request and pointer; outputs are valid, index and one-hot. It is purely combinational and instantiated once.
- The top level holds the FSM, pointer, credit counter and output registers.

## Test plan
- Reset and basic grant: `rst_n` low with `request`=4'b1111 gives all outputs 0. Release reset with weights all 1. Hold `ack` high continuously. Required grant sequence: 0001, 0010, 0100, 1000, 0001, one grant per cycle.
- Weight quota: weight = {1,3,2,4} for ports 3..0, all requesting, `ack` high, `last` low. Required hold lengths: port0 4 cycles, port1 2, port2 3, port3 1. `credit` counts 4,3,2,1 during port0's turn.
- Early `last`: port1 granted with weight 8. Assert `ack`+`last` on the 2nd beat. Grant moves to the next requester on the following cycle; `ptr`=2.
- Abandon: port2 granted, then `request[2]` drops with `ack` low. With `request`=4'b0001, the next cycle grants port 0. With `request`=0, the next cycle shows `grant_valid`=0 and all outputs 0.
- Single requester and weight 0: only port3 requests, weight 0, `ack` high. Port3 is re-granted every cycle with `credit`=1 and `grant_valid` never drops.
- Reset mid-operation: drop `rst_n` asynchronously between edges while port1 holds `credit`=3. Outputs clear immediately. After release, the first grant goes to the lowest-index requester (pointer back at 0).
